dropout_stream_unit: RTL

- Parametrised training-time dropout stage for the neuron datapath: N_CH channels of DW-bit unsigned activations enter as one beat and leave one cycle later.
- In each beat, channels are zeroed pseudo-randomly with a runtime-programmable drop rate.
- Uses a synthesizable per-channel 16-bit Galois LFSR and a valid/ready handshake on both sides.
- Sits between a layer's activation output and the next layer's input. With enable low it is a 1-cycle registered pass-through.

---
 rtl/dropout_pkg.sv | 28 ++
 rtl/dropout_lfsr16.sv | 26 ++
 rtl/dropout_stream_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/dropout_pkg.sv
// Shared constants and helpers for the dropout stream stage.
// Galois LFSR step and per-channel seed derivation live here.
package dropout_pkg;

    localparam int          LFSR_W      = 16;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_STRIDE = 16'h1F35;
    localparam int          RATE_W      = 8;

    function automatic logic [LFSR_W-1:0] seed_for_channel(
        input logic [LFSR_W-1:0] base,
        input int                c
    );
        logic [31:0]       prod;
        logic [LFSR_W-1:0] s;
        prod = 32'(c) * 32'(SEED_STRIDE);
        s    = base + prod[LFSR_W-1:0];
        // An all-zero Galois LFSR would lock up forever
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/dropout_lfsr16.sv
// One 16-bit Galois LFSR, right shift, with reload and advance.
// Reload has priority over advance.
module dropout_lfsr16
    import dropout_pkg::*;
#(
    parameter logic [LFSR_W-1:0] INIT = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else if (load) begin
            state <= load_value;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/dropout_stream_unit.sv
// Training-time dropout stage: one registered beat of N_CH channels.
// Define DROPOUT_SCALE_EN to scale kept channels by SCALE_Q44 (inverted dropout).
module dropout_stream_unit
    import dropout_pkg::*;
#(
    parameter int          N_CH      = 8,
    parameter int          DW        = 8,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [7:0]  SCALE_Q44 = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [RATE_W-1:0]    drop_rate,
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed_value,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CH*DW-1:0]   out_data,
    output logic [N_CH-1:0]      out_mask
);

    logic                accept;
    logic                advance;
    logic [N_CH-1:0]     mask_d;
    logic [N_CH*DW-1:0]  data_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign advance  = accept && enable;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [LFSR_W-1:0] lfsr;
        logic [DW-1:0]     din;
        logic [DW-1:0]     kept;

        dropout_lfsr16 #(
            .INIT (seed_for_channel(SEED, c))
        ) u_lfsr (
            .clk        (clk),
            .reset      (reset),
            .load       (seed_load),
            .load_value (seed_for_channel(seed_value, c)),
            .advance    (advance),
            .state      (lfsr)
        );

        assign din       = in_data[c*DW +: DW];
        assign mask_d[c] = enable && (lfsr[RATE_W-1:0] < drop_rate);

`ifdef DROPOUT_SCALE_EN
        logic [DW+7:0] prod;
        logic [DW+3:0] shr;
        assign prod = (DW+8)'(din) * (DW+8)'(SCALE_Q44);
        assign shr  = prod[DW+7:4];
        // Pass-through beats are never scaled
        assign kept = !enable ? din
                    : (|shr[DW+3:DW]) ? {DW{1'b1}} : shr[DW-1:0];
`else
        assign kept = din;
`endif

        assign data_d[c*DW +: DW] = mask_d[c] ? '0 : kept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= data_d;
            out_mask  <= mask_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
